// File: rtl/aetcam_write_scheduler_if.sv
// Request/clear/write-port bundle between the TCAM update logic, the write
// scheduler and the array's per-port address decoders.
interface aetcam_write_scheduler_if #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic [3:0]          req_valid;
  logic [3:0]          req_ready;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*WIDTH-1:0]  req_st;
  logic [4*WIDTH-1:0]  req_m;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;
  logic [3:0]          wr_en;
  logic [4*ADDR_W-1:0] wr_addr;
  logic [4*WIDTH-1:0]  wr_st;
  logic [4*WIDTH-1:0]  wr_m;

  modport master (
    output req_valid, req_addr, req_st, req_m, clr_req,
    input  req_ready, clr_busy, clr_done, wr_en, wr_addr, wr_st, wr_m
  );

  modport slave (
    input  req_valid, req_addr, req_st, req_m, clr_req,
    output req_ready, clr_busy, clr_done, wr_en, wr_addr, wr_st, wr_m
  );
endinterface

// File: rtl/aetcam_write_scheduler.sv
// Shares four TCAM write ports among four requesters (round-robin on equal
// addresses) and sequences a whole-array clear four entries per cycle.
module aetcam_write_scheduler #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic                     clk,
  input logic                     rst_n,
  aetcam_write_scheduler_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int GROUPS = DEPTH / 4;
  localparam int CNT_W  = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUPS - 1);

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_rr_ptr, w_rr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [3:0]          r_wr_en_p1, w_wr_en_nxt;
  logic [4*ADDR_W-1:0] r_wr_addr_p1, w_wr_addr_nxt;
  logic [4*WIDTH-1:0]  r_wr_st_p1, w_wr_st_nxt;
  logic [4*WIDTH-1:0]  r_wr_m_p1, w_wr_m_nxt;
  logic [3:0]          w_grant;
  logic [3:0]          w_ready;
  logic                w_accept;
  logic                w_conflict;

  // A requester loses only to a valid same-address requester nearer rr_ptr.
  always_comb begin
    logic [1:0] v_pr;
    logic [1:0] v_ps;
    w_grant = '0;
    v_pr    = '0;
    v_ps    = '0;
    for (int r = 0; r < 4; r++) begin
      v_pr       = 2'(r) - r_rr_ptr;
      w_grant[r] = bus.req_valid[r];
      for (int s = 0; s < 4; s++) begin
        v_ps = 2'(s) - r_rr_ptr;
        if ((s != r) && bus.req_valid[s] && (v_ps < v_pr) &&
            (bus.req_addr[s*ADDR_W +: ADDR_W] == bus.req_addr[r*ADDR_W +: ADDR_W]))
          w_grant[r] = 1'b0;
      end
    end
  end

  assign w_accept   = rst_n && (r_state == IDLE) && !bus.clr_req;
  assign w_ready    = w_accept ? w_grant : 4'b0000;
  assign w_conflict = w_accept && |(bus.req_valid & ~w_grant);

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_nxt      = r_rr_ptr;
    w_cnt_nxt     = r_cnt;
    w_wr_en_nxt   = 4'b0000;
    w_wr_addr_nxt = r_wr_addr_p1;
    w_wr_st_nxt   = r_wr_st_p1;
    w_wr_m_nxt    = r_wr_m_p1;
    case (r_state)
      IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_wr_en_nxt = 4'hF;
          w_wr_st_nxt = '0;
          w_wr_m_nxt  = '0;
          for (int p = 0; p < 4; p++)
            w_wr_addr_nxt[p*ADDR_W +: ADDR_W] = ADDR_W'(p);
        end else begin
          w_wr_en_nxt = w_grant;
          for (int p = 0; p < 4; p++) begin
            if (w_grant[p]) begin
              w_wr_addr_nxt[p*ADDR_W +: ADDR_W] = bus.req_addr[p*ADDR_W +: ADDR_W];
              w_wr_st_nxt[p*WIDTH +: WIDTH]     = bus.req_st[p*WIDTH +: WIDTH];
              w_wr_m_nxt[p*WIDTH +: WIDTH]      = bus.req_m[p*WIDTH +: WIDTH];
            end
          end
          if (w_conflict)
            w_rr_nxt = r_rr_ptr + 2'd1;
        end
      end
      CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_wr_en_nxt = 4'hF;
          w_wr_st_nxt = '0;
          w_wr_m_nxt  = '0;
          for (int p = 0; p < 4; p++)
            w_wr_addr_nxt[p*ADDR_W +: ADDR_W] = ADDR_W'(4 * (int'(r_cnt) + 1) + p);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered write-port drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= 2'd0;
      r_cnt        <= '0;
      r_wr_en_p1   <= 4'b0000;
      r_wr_addr_p1 <= '0;
      r_wr_st_p1   <= '0;
      r_wr_m_p1    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wr_en_p1   <= w_wr_en_nxt;
      r_wr_addr_p1 <= w_wr_addr_nxt;
      r_wr_st_p1   <= w_wr_st_nxt;
      r_wr_m_p1    <= w_wr_m_nxt;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.clr_busy  = (r_state == CLEAR);
  assign bus.clr_done  = (r_state == CLEAR) && (r_cnt == LAST);
  assign bus.wr_en     = r_wr_en_p1;
  assign bus.wr_addr   = r_wr_addr_p1;
  assign bus.wr_st     = r_wr_st_p1;
  assign bus.wr_m      = r_wr_m_p1;

endmodule
